// File: rtl/s2mm_capture_controller_pkg.sv
// Shared state encoding and sizing helpers for the S2MM triggered ring-buffer
// capture controller and its address generator.
package s2mm_capture_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_POST,
        ST_STOPPING,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int BURST_LEN_DEFAULT = 16;
    localparam int RESP_CNT_WIDTH    = 16;

    // Ceiling log2; clogb2(1) == 0.
    function automatic int clogb2(input int value);
        int result;
        int v;
        result = 0;
        for (v = value - 1; v > 0; v = v >> 1)
            result = result + 1;
        return result;
    endfunction

endpackage

// File: rtl/s2mm_ring_addr_gen.sv
// Ring offset and in-burst beat position for the capture stream; produces the
// byte address the writer packs with each forwarded beat.
module s2mm_ring_addr_gen
    import s2mm_capture_controller_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int CNT_WIDTH      = 20,
    parameter int BURST_LEN      = BURST_LEN_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           advance,
    input  logic [AXI_ADDR_WIDTH-1:0]      cfg_base,
    input  logic [CNT_WIDTH-1:0]           cfg_words,
    output logic [AXI_ADDR_WIDTH-1:0]      address,
    output logic [clogb2(BURST_LEN)-1:0]   beat_in_burst
);

    localparam int BYTE_SHIFT = clogb2(AXI_DATA_WIDTH / 8);
    localparam int BB_W       = clogb2(BURST_LEN);

    logic [CNT_WIDTH-1:0] offset;
    logic                 at_wrap;

    assign at_wrap = (offset == cfg_words - CNT_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset        <= '0;
            beat_in_burst <= '0;
        end else if (clear) begin
            offset        <= '0;
            beat_in_burst <= '0;
        end else if (advance) begin
            offset        <= at_wrap ? '0 : offset + CNT_WIDTH'(1);
            // Power-of-two burst length, so the counter wraps naturally.
            beat_in_burst <= beat_in_burst + BB_W'(1);
        end
    end

    assign address = cfg_base + (AXI_ADDR_WIDTH'(offset) << BYTE_SHIFT);

endmodule

// File: rtl/s2mm_capture_controller.sv
// Triggered ring-buffer capture sequencer in front of the S2MM RAM writer:
// gates the sample stream, stops on burst boundaries, waits for all B responses.
module s2mm_capture_controller
    import s2mm_capture_controller_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 32,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNT_WIDTH        = 20,
    parameter int BURST_LEN        = BURST_LEN_DEFAULT
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXI_ADDR_WIDTH-1:0]   cfg_base,
    input  logic [CNT_WIDTH-1:0]        cfg_words,
    input  logic [CNT_WIDTH-1:0]        cfg_post,
    input  logic                        arm,
    input  logic                        trigger,
    input  logic                        abort,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic                        S_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic [AXI_ADDR_WIDTH-1:0]   address,
    input  logic                        M_AXI_bvalid,
    input  logic [1:0]                  M_AXI_bresp,
    output logic                        busy,
    output logic                        triggered,
    output logic                        done,
    output logic                        error,
    output logic [AXI_ADDR_WIDTH-1:0]   trigger_addr,
    output logic [AXI_ADDR_WIDTH-1:0]   last_addr
);

    localparam int BB_W = clogb2(BURST_LEN);

    state_t                    state;
    logic                      forwarding;
    logic                      beat;
    logic                      arm_go;
    logic [BB_W-1:0]           beat_in_burst;
    logic [BB_W-1:0]           bib_next;
    logic                      at_boundary;
    logic                      last_beat;
    logic [CNT_WIDTH-1:0]      post_cnt;
    logic [CNT_WIDTH-1:0]      post_next;
    logic [CNT_WIDTH-1:0]      post_thr;
    logic                      post_done;
    logic                      trig_pend;
    logic [RESP_CNT_WIDTH-1:0] bursts_issued;
    logic [RESP_CNT_WIDTH-1:0] bursts_acked;

    assign forwarding    = (state == ST_ARMED) || (state == ST_POST) || (state == ST_STOPPING);
    assign M_AXIS_tdata  = S_AXIS_tdata;
    assign M_AXIS_tvalid = forwarding & S_AXIS_tvalid;
    assign S_AXIS_tready = forwarding ? M_AXIS_tready : 1'b1;
    assign beat          = M_AXIS_tvalid & M_AXIS_tready;
    assign arm_go        = arm && ((state == ST_IDLE) || (state == ST_DONE));

    // Boundary decisions look at the position after this cycle's beat, so a
    // stop never leaves a partial burst behind in the writer.
    assign bib_next    = beat ? beat_in_burst + BB_W'(1) : beat_in_burst;
    assign at_boundary = (bib_next == '0);
    assign last_beat   = (beat_in_burst == BB_W'(BURST_LEN - 1));

    // The trigger beat itself is not a post-trigger beat.
    assign post_thr  = cfg_post & ~CNT_WIDTH'(BURST_LEN - 1);
    assign post_next = post_cnt + CNT_WIDTH'(beat && !trig_pend);
    assign post_done = (post_next >= post_thr) && at_boundary && (!trig_pend || beat);

    s2mm_ring_addr_gen #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .CNT_WIDTH      (CNT_WIDTH),
        .BURST_LEN      (BURST_LEN)
    ) u_addr_gen (
        .clk           (aclk),
        .rst           (areset),
        .clear         (arm_go),
        .advance       (beat),
        .cfg_base      (cfg_base),
        .cfg_words     (cfg_words),
        .address       (address),
        .beat_in_burst (beat_in_burst)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bursts_issued <= '0;
            bursts_acked  <= '0;
            error         <= 1'b0;
        end else if (arm_go) begin
            bursts_issued <= '0;
            bursts_acked  <= '0;
            error         <= 1'b0;
        end else begin
            if (beat && last_beat)
                bursts_issued <= bursts_issued + RESP_CNT_WIDTH'(1);
            if (M_AXI_bvalid)
                bursts_acked <= bursts_acked + RESP_CNT_WIDTH'(1);
            if (M_AXI_bvalid && (M_AXI_bresp != 2'b00))
                error <= 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            triggered    <= 1'b0;
            done         <= 1'b0;
            trigger_addr <= '0;
            last_addr    <= '0;
            post_cnt     <= '0;
            trig_pend    <= 1'b0;
        end else begin
            if (beat)
                last_addr <= address;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state     <= ST_ARMED;
                        busy      <= 1'b1;
                        triggered <= 1'b0;
                        done      <= 1'b0;
                        trig_pend <= 1'b0;
                        post_cnt  <= '0;
                    end
                end
                ST_ARMED: begin
                    if (abort) begin
                        state <= at_boundary ? ST_DRAIN : ST_STOPPING;
                    end else if (trigger) begin
                        triggered <= 1'b1;
                        post_cnt  <= '0;
                        if (beat)
                            trigger_addr <= address;
                        else
                            trig_pend <= 1'b1;
                        // A zero post count with the trigger beat closing a burst stops here.
                        if (beat && at_boundary && (post_thr == '0))
                            state <= ST_DRAIN;
                        else
                            state <= ST_POST;
                    end
                end
                ST_POST: begin
                    if (beat && trig_pend) begin
                        trigger_addr <= address;
                        trig_pend    <= 1'b0;
                    end
                    if (abort)
                        state <= at_boundary ? ST_DRAIN : ST_STOPPING;
                    else if (post_done)
                        state <= ST_DRAIN;
                    else
                        post_cnt <= post_next;
                end
                ST_STOPPING: begin
                    if (beat && trig_pend) begin
                        trigger_addr <= address;
                        trig_pend    <= 1'b0;
                    end
                    if (at_boundary)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (bursts_acked == bursts_issued) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s2mm_capture_controller.sv
// Randomized bench for s2mm_capture_controller: drives a counting sample stream
// and B responses, and compares every beat and the run summary to a simple model.
module tb_s2mm_capture_controller;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 32;
    localparam int CW = 20;
    localparam int BL = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic [AW-1:0] cfg_base;
    logic [CW-1:0] cfg_words;
    logic [CW-1:0] cfg_post;
    logic          arm, trigger, abort;
    logic [TW-1:0] s_tdata;
    logic          s_tvalid, s_tready;
    logic [TW-1:0] m_tdata;
    logic          m_tvalid, m_tready;
    logic [AW-1:0] address;
    logic          bvalid;
    logic [1:0]    bresp;
    logic          busy, triggered, done, error;
    logic [AW-1:0] trigger_addr, last_addr;

    logic [TW-1:0] src;
    int n_pass   = 0;
    int n_checks = 0;

    always #5 aclk = ~aclk;

    s2mm_capture_controller #(
        .AXI_ADDR_WIDTH   (AW),
        .AXI_DATA_WIDTH   (DW),
        .AXIS_TDATA_WIDTH (TW),
        .CNT_WIDTH        (CW),
        .BURST_LEN        (BL)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_base      (cfg_base),
        .cfg_words     (cfg_words),
        .cfg_post      (cfg_post),
        .arm           (arm),
        .trigger       (trigger),
        .abort         (abort),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tready (s_tready),
        .M_AXIS_tdata  (m_tdata),
        .M_AXIS_tvalid (m_tvalid),
        .M_AXIS_tready (m_tready),
        .address       (address),
        .M_AXI_bvalid  (bvalid),
        .M_AXI_bresp   (bresp),
        .busy          (busy),
        .triggered     (triggered),
        .done          (done),
        .error         (error),
        .trigger_addr  (trigger_addr),
        .last_addr     (last_addr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_busy"},      64'(busy), 64'(0));
        chk({nm, "_trig"},      64'(triggered), 64'(0));
        chk({nm, "_done"},      64'(done), 64'(0));
        chk({nm, "_error"},     64'(error), 64'(0));
        chk({nm, "_trig_addr"}, 64'(trigger_addr), 64'(0));
        chk({nm, "_last_addr"}, 64'(last_addr), 64'(0));
        chk({nm, "_mvalid"},    64'(m_tvalid), 64'(0));
        chk({nm, "_sready"},    64'(s_tready), 64'(1));
        chk({nm, "_address"},   64'(address), 64'(cfg_base));
    endtask

    // One capture run. trig_at/abort_at are forwarded-beat indices (-1 = none);
    // stop_at >= 0 leaves the run in flight after that many beats.
    task automatic run_cap(input string nm, input logic [AW-1:0] base, input int words,
                           input int post, input int trig_at, input int abort_at,
                           input int vpct, input int rpct, input int err_idx,
                           input int stop_at, input int bdly);
        int L, post_m, k, acks, resp_idx, cyc, acks_at_done;
        bit trig_sent, ab_sent, fin, err_exp, timed_out;
        int due[$];
        logic [TW-1:0] d0;
        logic [AW-1:0] exp_addr;

        post_m = post & ~(BL - 1);
        if (trig_at >= 0) L = ((trig_at + post_m) / BL + 1) * BL - 1;
        else              L = (abort_at / BL + 1) * BL - 1;

        cfg_base  = base;
        cfg_words = CW'(words);
        cfg_post  = CW'(post);
        arm = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
        @(posedge aclk); #1;
        arm = 1'b0;

        k = 0; acks = 0; resp_idx = 0; cyc = 0; acks_at_done = 0; d0 = '0;
        trig_sent = 0; ab_sent = 0; fin = 0; err_exp = 0; timed_out = 0;
        while (!fin) begin
            s_tvalid = ($urandom_range(99) < vpct);
            m_tready = ($urandom_range(99) < rpct);
            trigger = 1'b0;
            abort   = 1'b0;
            if (trig_at >= 0 && !trig_sent && k == trig_at) begin
                s_tvalid = 1'b1; m_tready = 1'b1; trigger = 1'b1; trig_sent = 1;
            end
            if (abort_at >= 0 && !ab_sent && k == abort_at) begin
                s_tvalid = 1'b1; m_tready = 1'b1; abort = 1'b1; ab_sent = 1;
            end
            s_tdata = src;
            bvalid = 1'b0; bresp = 2'b00;
            if (due.size() > 0 && due[0] <= cyc) begin
                void'(due.pop_front());
                bvalid = 1'b1;
                if (resp_idx == err_idx) begin bresp = 2'b10; err_exp = 1; end
                resp_idx++;
                acks++;
            end

            @(negedge aclk);
            if (cyc == 0) begin
                chk({nm, "_busy_on_arm"}, 64'(busy), 64'(1));
                chk({nm, "_done_clr"},    64'(done), 64'(0));
                chk({nm, "_error_clr"},   64'(error), 64'(0));
            end
            if (m_tvalid && m_tready) begin
                exp_addr = base + AW'((k % words) * (DW / 8));
                chk({nm, "_addr"}, 64'(address), 64'(exp_addr));
                if (k == 0) d0 = m_tdata;
                else chk({nm, "_data"}, 64'(m_tdata), 64'(d0 + TW'(k)));
                k++;
                if (k % BL == 0) due.push_back(cyc + $urandom_range(2, bdly));
            end
            if (s_tvalid && s_tready) src = src + 1;
            if (done) begin
                fin = 1;
                acks_at_done = acks - (bvalid ? 1 : 0);
            end
            if (stop_at >= 0 && k >= stop_at) fin = 1;
            cyc++;
            if (cyc > 4000) begin fin = 1; timed_out = 1; end
            @(posedge aclk); #1;
        end
        trigger = 1'b0; abort = 1'b0; bvalid = 1'b0; bresp = 2'b00;

        if (timed_out) chk({nm, "_timeout"}, 64'(1), 64'(0));
        if (stop_at < 0) begin
            chk({nm, "_beats"},     64'(k), 64'(L + 1));
            chk({nm, "_acks_done"}, 64'(acks_at_done), 64'((L + 1) / BL));
            chk({nm, "_triggered"}, 64'(triggered), 64'(trig_at >= 0));
            if (trig_at >= 0)
                chk({nm, "_trig_addr"}, 64'(trigger_addr),
                    64'(base + AW'((trig_at % words) * (DW / 8))));
            chk({nm, "_last_addr"}, 64'(last_addr), 64'(base + AW'((L % words) * (DW / 8))));
            chk({nm, "_error"},     64'(error), 64'(err_exp));
            chk({nm, "_busy_end"},  64'(busy), 64'(0));
            chk({nm, "_mvalid_end"}, 64'(m_tvalid), 64'(0));
        end
    endtask

    initial begin
        logic [AW-1:0] rb;
        areset = 1'b1;
        cfg_base = 32'h2000_0000; cfg_words = CW'(64); cfg_post = '0;
        arm = 1'b0; trigger = 1'b0; abort = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        src = 32'h100;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("por");
        areset = 1'b0;
        @(posedge aclk); #1;

        run_cap("basic",   32'h1000_0000, 64, 32, 10, -1, 100, 100, -1, -1, 8);
        run_cap("wrap",    32'h1000_0000, 32, 16, 40, -1, 100, 100, -1, -1, 8);
        run_cap("abort5",  32'h1000_0000, 64, 32, -1,  5, 100, 100, -1, -1, 8);
        run_cap("abort15", 32'h1000_0000, 64, 32, -1, 15, 100, 100, -1, -1, 8);
        run_cap("bp",      32'h1000_0000, 64, 32, 10, -1, 80,  50,  -1, -1, 8);
        run_cap("bresp",   32'h1000_0000, 64, 32, 10, -1, 100, 100,  1, -1, 8);
        run_cap("post0",   32'h1000_0400, 64,  0, 15, -1, 100, 100, -1, -1, 8);
        run_cap("post_lo", 32'h1000_0400, 48,  7, 20, -1, 90,  70,  -1, -1, 8);

        // Reset in POST with two bursts issued and their responses still pending.
        run_cap("rst_mid", 32'h1000_0000, 64, 32, 10, -1, 100, 100, -1, 40, 300);
        areset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(posedge aclk); #1;
        run_cap("after_rst", 32'h1000_0000, 64, 32, 10, -1, 100, 100, -1, -1, 8);

        for (int i = 0; i < 6; i++) begin
            rb = $urandom;
            rb[5:0] = '0;
            run_cap("rand", rb, 16 * $urandom_range(1, 8), $urandom_range(0, 100),
                    $urandom_range(0, 60), -1, $urandom_range(60, 100),
                    $urandom_range(50, 100), $urandom_range(0, 4), -1, 10);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
